fetch_stage: RTL and testbench

//  PC register, instruction-memory address drive and IF/ID pipeline register for the 5-stage core.

---
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory address drive and IF/ID pipeline register.
// Honours hazard-unit stalls and squashes IF/ID with a bubble on EX-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            imem_addr,
    output logic [31:0]            pc,
    output logic [31:0]            if_id_pc,
    output logic [31:0]            if_id_instr,
    output logic                   if_id_valid,
    output logic [1:0]             fetch_state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] target_aligned;
    logic        stall_eff;

    // Redirect targets are forced to word alignment.
    assign target_aligned = redirect_target & ~32'd3;

    // A redirect overrides a concurrent stall.
    assign stall_eff = stall & ~redirect;

    assign imem_addr   = pc;
    assign fetch_state = state;

    // PC and IF/ID: priority redirect > stall > advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= target_aligned;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc          <= pc + 32'd4;
            if_id_pc    <= pc;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

    // Fetch FSM: stall never moves it; the illegal encoding falls back to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:     state <= redirect ? REDIRECT : RUN;
                RUN:      state <= redirect ? REDIRECT : RUN;
                REDIRECT: state <= redirect ? REDIRECT : RUN;
                default:  state <= RUN;
            endcase
        end
    end

    // Saturating perf counter of effective stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_eff && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage, plus sequences for stall saturation
// and asynchronous mid-stall reset. A narrow-counter instance shares all inputs.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic [31:0] imem_rdata, imem_addr, pc, if_id_pc, if_id_instr;
    logic        if_id_valid;
    logic [1:0]  fetch_state;
    logic [15:0] stall_count;

    logic [31:0] s_imem_rdata, s_imem_addr, s_pc, s_if_id_pc, s_if_id_instr;
    logic        s_if_id_valid;
    logic [1:0]  s_fetch_state;
    logic [3:0]  s_stall_count;

    int checks;
    int failures;

    // Instruction memory model: content derived from the address.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata   = instr_at(imem_addr);
    assign s_imem_rdata = instr_at(s_imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc(pc), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_state(fetch_state), .stall_count(stall_count)
    );

    fetch_stage #(.STALL_CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_rdata(s_imem_rdata),
        .imem_addr(s_imem_addr), .pc(s_pc), .if_id_pc(s_if_id_pc),
        .if_id_instr(s_if_id_instr), .if_id_valid(s_if_id_valid),
        .fetch_state(s_fetch_state), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc"},        pc,                  32'h0);
        chk({tag, " imem_addr"}, imem_addr,           32'h0);
        chk({tag, " if_id_pc"},  if_id_pc,            32'h0);
        chk({tag, " instr"},     if_id_instr,         NOP);
        chk({tag, " valid"},     32'(if_id_valid),    32'h0);
        chk({tag, " state"},     32'(fetch_state),    32'h0);
        chk({tag, " scnt"},      32'(stall_count),    32'h0);
        chk({tag, " small scnt"}, 32'(s_stall_count), 32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] if_pc;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  state;
        logic [15:0] scnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic [31:0] p, input logic [31:0] ip,
                                input logic [31:0] ins, input logic v,
                                input logic [1:0] st, input logic [15:0] sc);
        vec_t x;
        x.stall = s; x.redirect = r; x.target = t; x.pc = p; x.if_pc = ip;
        x.instr = ins; x.valid = v; x.state = st; x.scnt = sc;
        return x;
    endfunction

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        checks   = 0;
        failures = 0;

        // Expected state after each edge; instr_at(A) = A ^ 0xDEAD0000.
        vecs[0]  = mk(0, 0, 32'h0,        32'h4,        32'h0,        32'hDEAD_0000, 1, 2'd1, 16'd0);
        vecs[1]  = mk(0, 0, 32'h0,        32'h8,        32'h4,        32'hDEAD_0004, 1, 2'd1, 16'd0);
        vecs[2]  = mk(0, 0, 32'h0,        32'hC,        32'h8,        32'hDEAD_0008, 1, 2'd1, 16'd0);
        vecs[3]  = mk(0, 0, 32'h0,        32'h10,       32'hC,        32'hDEAD_000C, 1, 2'd1, 16'd0);
        vecs[4]  = mk(1, 0, 32'h0,        32'h10,       32'hC,        32'hDEAD_000C, 1, 2'd1, 16'd1);
        vecs[5]  = mk(1, 0, 32'h0,        32'h10,       32'hC,        32'hDEAD_000C, 1, 2'd1, 16'd2);
        vecs[6]  = mk(1, 0, 32'h0,        32'h10,       32'hC,        32'hDEAD_000C, 1, 2'd1, 16'd3);
        vecs[7]  = mk(0, 0, 32'h0,        32'h14,       32'h10,       32'hDEAD_0010, 1, 2'd1, 16'd3);
        vecs[8]  = mk(0, 0, 32'h0,        32'h18,       32'h14,       32'hDEAD_0014, 1, 2'd1, 16'd3);
        vecs[9]  = mk(0, 0, 32'h0,        32'h1C,       32'h18,       32'hDEAD_0018, 1, 2'd1, 16'd3);
        vecs[10] = mk(0, 0, 32'h0,        32'h20,       32'h1C,       32'hDEAD_001C, 1, 2'd1, 16'd3);
        vecs[11] = mk(0, 1, 32'h102,      32'h100,      32'h0,        NOP,           0, 2'd2, 16'd3);
        vecs[12] = mk(0, 0, 32'h0,        32'h104,      32'h100,      32'hDEAD_0100, 1, 2'd1, 16'd3);
        vecs[13] = mk(1, 1, 32'h40,       32'h40,       32'h0,        NOP,           0, 2'd2, 16'd3);
        vecs[14] = mk(0, 0, 32'h0,        32'h44,       32'h40,       32'hDEAD_0040, 1, 2'd1, 16'd3);
        vecs[15] = mk(0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,      NOP,           0, 2'd2, 16'd3);
        vecs[16] = mk(0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h2152_FFFC, 1, 2'd1, 16'd3);
        vecs[17] = mk(0, 1, 32'h200,      32'h200,      32'h0,        NOP,           0, 2'd2, 16'd3);
        vecs[18] = mk(0, 1, 32'h301,      32'h300,      32'h0,        NOP,           0, 2'd2, 16'd3);
        vecs[19] = mk(0, 0, 32'h0,        32'h304,      32'h300,      32'hDEAD_0300, 1, 2'd1, 16'd3);

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        #12;
        chk_reset("reset");
        #10 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall           = vecs[i].stall;
            redirect        = vecs[i].redirect;
            redirect_target = vecs[i].target;
            @(posedge clk); #1;
            chk($sformatf("v%0d pc", i),        pc,                vecs[i].pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr,         vecs[i].pc);
            chk($sformatf("v%0d if_id_pc", i),  if_id_pc,          vecs[i].if_pc);
            chk($sformatf("v%0d instr", i),     if_id_instr,       vecs[i].instr);
            chk($sformatf("v%0d valid", i),     32'(if_id_valid),  32'(vecs[i].valid));
            chk($sformatf("v%0d state", i),     32'(fetch_state),  32'(vecs[i].state));
            chk($sformatf("v%0d scnt", i),      32'(stall_count),  32'(vecs[i].scnt));
            chk($sformatf("v%0d small pc", i),  s_pc,              vecs[i].pc);
        end

        // 20 stall cycles: narrow counter saturates at 0xF, wide one keeps counting.
        stall = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 11) chk("small scnt reaches max", 32'(s_stall_count), 32'hF);
        end
        chk("small scnt saturated", 32'(s_stall_count), 32'hF);
        chk("wide scnt",            32'(stall_count),   32'd23);
        chk("stall pc held",        pc,                 32'h304);
        chk("stall if_id_pc held",  if_id_pc,           32'h300);
        chk("stall instr held",     if_id_instr,        32'hDEAD_0300);
        chk("stall state",          32'(fetch_state),   32'h1);

        // Asynchronous reset mid-stall, away from any clock edge.
        #3 rst = 1'b1;
        #1;
        chk_reset("async reset");
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        chk("restart pc",       pc,               32'h4);
        chk("restart if_id_pc", if_id_pc,         32'h0);
        chk("restart instr",    if_id_instr,      32'hDEAD_0000);
        chk("restart valid",    32'(if_id_valid), 32'h1);
        chk("restart state",    32'(fetch_state), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
